hist_curve_calc: RTL and testbench



---
 rtl/hist_pkg.sv | 35 +++
 rtl/curve_skid_buf.sv | 45 ++++
 rtl/hist_curve_calc.sv | 181 ++++++++++++++++++
 tb/tb_hist_curve_calc.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram tone-curve stage.
// Optional clip-limit support is controlled by the CURVE_CLIP_LIMIT_EN macro.
package hist_pkg;
   localparam int BIN_NUM    = 128;
   localparam int ADDR_W     = 7;
   localparam int CNT_W      = 16;
   localparam int TOTAL_LOG2 = 15;
   localparam int BLK_W      = 7;
   localparam int EXC_W      = 23;
   localparam int CDF_W      = 23;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLIP      = 3'd1,
      ST_CLIP_WAIT = 3'd2,
      ST_CURVE     = 3'd3,
      ST_DRAIN     = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic [BLK_W-1:0]  block;
   } curve_entry_t;

   // min(255, cdf*255 >> TOTAL_LOG2), with cdf*255 formed as (cdf<<8)-cdf.
   function automatic logic [7:0] curve_value(input logic [CDF_W-1:0] cdf);
      logic [30:0] prod;
      logic [30:0] scaled;
      prod   = ({8'd0, cdf} << 8) - {8'd0, cdf};
      scaled = prod >> TOTAL_LOG2;
      curve_value = (scaled > 31'd255) ? 8'hFF : scaled[7:0];
   endfunction
endpackage

// File: rtl/curve_skid_buf.sv
// Two-entry valid/ready buffer for curve entries; the head entry stays
// stable while valid is high and ready is low.
module curve_skid_buf
   import hist_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  curve_entry_t push_data,
   input  logic         ready,
   output logic         valid,
   output curve_entry_t data,
   output logic [1:0]   count
);

   curve_entry_t mem [0:1];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         pop;

   assign valid = (count != 2'd0);
   assign data  = mem[rd_ptr];
   assign pop   = valid & ready;

   // The producer only pushes when an entry is free, so no overflow guard here.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/hist_curve_calc.sv
// Reads a block histogram, optionally clips and redistributes (CURVE_CLIP_LIMIT_EN),
// builds the CDF and streams a 128-entry tone curve while clearing each bin.
module hist_curve_calc
   import hist_pkg::*;
(
   input  logic             pclk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [BLK_W-1:0] block_idx_i,
   input  logic [CNT_W-1:0] clip_limit_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             hist_rd_o,
   output logic [6:0]       hist_addr_o,
   input  logic [CNT_W-1:0] hist_data_i,
   output logic             hist_clr_o,
   output logic [6:0]       hist_clr_addr_o,
   output logic             curve_valid_o,
   input  logic             curve_ready_i,
   output logic [6:0]       curve_addr_o,
   output logic [7:0]       curve_data_o,
   output logic [BLK_W-1:0] curve_block_o
);

   state_t            state;
   state_t            state_next;
   logic [BLK_W-1:0]  block_q;
   logic [7:0]        issue_cnt;
   logic              rd_pending;
   logic [6:0]        pend_addr;
   logic [CDF_W-1:0]  cdf;
   logic [CDF_W-1:0]  cdf_next;
   logic [CNT_W-1:0]  clip_w;
   logic [CNT_W-1:0]  add_w;
   logic [CNT_W-1:0]  h_min;
   logic [CNT_W:0]    b_w;
   logic [1:0]        skid_count;
   logic              skid_pop;
   logic [2:0]        occupancy;
   logic              issue_ok;
   logic              push;
   logic              start_ok;
   curve_entry_t      push_entry;
   curve_entry_t      out_entry;

`ifdef CURVE_CLIP_LIMIT_EN
   localparam state_t FIRST_PHASE = ST_CLIP;
   logic [CNT_W-1:0] clip_q;
   logic [EXC_W-1:0] excess;
   logic [EXC_W-1:0] excess_inc;
   logic [EXC_W-1:0] add_full;
   logic [CNT_W-1:0] over;

   assign over       = hist_data_i - clip_q;
   assign excess_inc = (hist_data_i > clip_q) ? {7'd0, over} : '0;
   assign add_full   = excess >> 7;
   assign add_w      = (add_full > {7'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : add_full[CNT_W-1:0];
   assign clip_w     = clip_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         clip_q <= '0;
         excess <= '0;
      end else if (start_ok) begin
         clip_q <= clip_limit_i;
         excess <= '0;
      end else if (rd_pending && (state == ST_CLIP || state == ST_CLIP_WAIT)) begin
         excess <= excess + excess_inc;
      end
   end
`else
   localparam state_t FIRST_PHASE = ST_CURVE;
   logic unused_clip;

   // Without clipping the min() below is a pass-through and nothing is added.
   assign clip_w      = {CNT_W{1'b1}};
   assign add_w       = '0;
   assign unused_clip = ^clip_limit_i;
`endif

   assign start_ok   = (state == ST_IDLE) && start_i;
   assign skid_pop   = curve_valid_o & curve_ready_i;
   // Occupancy the skid buffer will have once this cycle's traffic settles.
   assign occupancy  = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, skid_pop};
   assign issue_ok   = (issue_cnt < 8'd128) && (occupancy < 3'd2);
   assign push       = (state == ST_CURVE) && rd_pending;
   assign h_min      = (hist_data_i < clip_w) ? hist_data_i : clip_w;
   assign b_w        = {1'b0, h_min} + {1'b0, add_w};
   assign cdf_next   = cdf + {6'd0, b_w};
   assign push_entry = '{addr: pend_addr, data: curve_value(cdf_next), block: block_q};

   always_ff @(posedge pclk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (start_i) state_next = FIRST_PHASE;
         ST_CLIP:      if (issue_cnt == 8'd127) state_next = ST_CLIP_WAIT;
         ST_CLIP_WAIT: state_next = ST_CURVE;
         ST_CURVE:     if (issue_cnt == 8'd128 && !rd_pending) state_next = ST_DRAIN;
         ST_DRAIN:     if (skid_count == 2'd0) state_next = ST_DONE;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o          = 1'b0;
      done_o          = 1'b0;
      hist_rd_o       = 1'b0;
      hist_addr_o     = '0;
      hist_clr_o      = 1'b0;
      hist_clr_addr_o = '0;
      case (state)
         ST_CLIP: begin
            busy_o      = 1'b1;
            hist_rd_o   = 1'b1;
            hist_addr_o = issue_cnt[6:0];
         end
         ST_CLIP_WAIT: busy_o = 1'b1;
         ST_CURVE: begin
            busy_o          = 1'b1;
            hist_rd_o       = issue_ok;
            hist_addr_o     = issue_ok ? issue_cnt[6:0] : 7'd0;
            hist_clr_o      = rd_pending;
            hist_clr_addr_o = rd_pending ? pend_addr : 7'd0;
         end
         ST_DRAIN: busy_o = 1'b1;
         ST_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         block_q    <= '0;
         issue_cnt  <= '0;
         rd_pending <= 1'b0;
         pend_addr  <= '0;
         cdf        <= '0;
      end else begin
         rd_pending <= hist_rd_o;
         pend_addr  <= hist_addr_o;
         if (start_ok) begin
            block_q   <= block_idx_i;
            issue_cnt <= '0;
         end else if (state == ST_CLIP_WAIT) begin
            issue_cnt <= '0;
         end else if (hist_rd_o) begin
            issue_cnt <= issue_cnt + 8'd1;
         end
         if (start_ok) begin
            cdf <= '0;
         end else if (push) begin
            cdf <= cdf_next;
         end
      end
   end

   curve_skid_buf u_skid (
      .clk       (pclk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .ready     (curve_ready_i),
      .valid     (curve_valid_o),
      .data      (out_entry),
      .count     (skid_count)
   );

   assign curve_addr_o  = out_entry.addr;
   assign curve_data_o  = out_entry.data;
   assign curve_block_o = out_entry.block;

endmodule

// File: tb/tb_hist_curve_calc.sv
// Self-checking bench for hist_curve_calc: histogram memory model, curve scoreboard,
// and a reference tone-curve model that follows CURVE_CLIP_LIMIT_EN.
module tb_hist_curve_calc;
   import hist_pkg::*;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [6:0]  block_idx_i = '0;
   logic [15:0] clip_limit_i = '0;
   logic        busy_o, done_o, hist_rd_o, hist_clr_o, curve_valid_o;
   logic [6:0]  hist_addr_o, hist_clr_addr_o, curve_addr_o, curve_block_o;
   logic [15:0] hist_data_i = '0;
   logic        curve_ready_i = 1'b1;
   logic [7:0]  curve_data_o;

   int n_checks = 0;
   int n_pass = 0;

   always #5 pclk = ~pclk;

   hist_curve_calc dut (
      .pclk(pclk), .rst(rst), .start_i(start_i), .block_idx_i(block_idx_i),
      .clip_limit_i(clip_limit_i), .busy_o(busy_o), .done_o(done_o),
      .hist_rd_o(hist_rd_o), .hist_addr_o(hist_addr_o), .hist_data_i(hist_data_i),
      .hist_clr_o(hist_clr_o), .hist_clr_addr_o(hist_clr_addr_o),
      .curve_valid_o(curve_valid_o), .curve_ready_i(curve_ready_i),
      .curve_addr_o(curve_addr_o), .curve_data_o(curve_data_o), .curve_block_o(curve_block_o)
   );

   // histogram memory: data one cycle after a read, garbage otherwise
   int hist_mem [128];
   int ref_hist [128];
   bit clr_seen [128];
   int clr_cnt;

   always @(posedge pclk) begin
      if (hist_rd_o) hist_data_i <= 16'(hist_mem[hist_addr_o]);
      else           hist_data_i <= 16'($urandom);
      if (hist_clr_o) begin
         hist_mem[hist_clr_addr_o] = 0;
         clr_cnt = clr_cnt + 1;
         clr_seen[hist_clr_addr_o] = 1'b1;
      end
   end

   // scoreboard capture
   logic [21:0] got_q[$];
   logic [21:0] exp_q[$];
   int done_cnt;
   int done_busy_bad;
   bit rand_ready = 1'b0;

   always @(negedge pclk) begin
      if (!rst) begin
         if (curve_valid_o && curve_ready_i) got_q.push_back({curve_addr_o, curve_data_o, curve_block_o});
         if (done_o) begin
            done_cnt = done_cnt + 1;
            if (busy_o) done_busy_bad = done_busy_bad + 1;
         end
      end
   end

   always @(posedge pclk) begin
      if (rand_ready) begin
         #1 curve_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   // reference model: clip/redistribute, CDF, scale to 8 bits
   task automatic build_expected(input int blk, input int clip);
      longint excess, add, clip_eff, cdf, b, v;
      excess = 0;
      add = 0;
      clip_eff = clip;
      exp_q.delete();
`ifdef CURVE_CLIP_LIMIT_EN
      for (int i = 0; i < 128; i++) if (ref_hist[i] > clip) excess += ref_hist[i] - clip;
      add = excess / 128;
      if (add > 65535) add = 65535;
`else
      clip_eff = 64'd1 << 40;
`endif
      cdf = 0;
      for (int i = 0; i < 128; i++) begin
         b = ((ref_hist[i] < clip_eff) ? ref_hist[i] : clip_eff) + add;
         cdf += b;
         v = (cdf * 255) / 32768;
         if (v > 255) v = 255;
         exp_q.push_back({7'(i), 8'(v), 7'(blk)});
      end
   endtask

   function automatic logic [7:0] got_data(input int idx);
      logic [21:0] e;
      e = (idx < got_q.size()) ? got_q[idx] : 22'h3FFFFF;
      return e[14:7];
   endfunction

   task automatic fill_uniform();
      for (int i = 0; i < 128; i++) begin hist_mem[i] = 256; ref_hist[i] = 256; end
   endtask

   task automatic fill_single();
      for (int i = 0; i < 128; i++) begin hist_mem[i] = 0; ref_hist[i] = 0; end
      hist_mem[64] = 32768;
      ref_hist[64] = 32768;
   endtask

   task automatic fill_random();
      int remaining, amt, bin;
      for (int i = 0; i < 128; i++) hist_mem[i] = 0;
      remaining = 32768;
      while (remaining > 0) begin
         amt = $urandom_range(1, (remaining < 1500) ? remaining : 1500);
         bin = $urandom_range(0, 127);
         hist_mem[bin] += amt;
         remaining -= amt;
      end
      for (int i = 0; i < 128; i++) ref_hist[i] = hist_mem[i];
   endtask

   task automatic start_block(input int blk, input int clip);
      got_q.delete();
      done_cnt = 0;
      done_busy_bad = 0;
      clr_cnt = 0;
      for (int i = 0; i < 128; i++) clr_seen[i] = 1'b0;
      @(posedge pclk);
      #1;
      start_i = 1'b1;
      block_idx_i = 7'(blk);
      clip_limit_i = 16'(clip);
      @(posedge pclk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(output bit timed_out);
      for (int c = 0; c < 3000; c++) begin
         @(negedge pclk);
         if (done_cnt > 0) break;
      end
      timed_out = (done_cnt == 0);
      repeat (4) @(negedge pclk);
   endtask

   task automatic test_reset();
      repeat (4) @(negedge pclk);
      n_checks++;
      if ({busy_o, done_o, hist_rd_o, hist_clr_o, curve_valid_o} !== 5'b0)
         $display("FAIL reset_ctrl: got %b want 00000", {busy_o, done_o, hist_rd_o, hist_clr_o, curve_valid_o});
      else n_pass++;
      @(posedge pclk);
      #1 rst = 1'b0;
      @(negedge pclk);
      n_checks++;
      if ({busy_o, curve_valid_o, curve_addr_o, curve_data_o, curve_block_o, hist_addr_o, hist_clr_addr_o} !== '0)
         $display("FAIL reset_data: busy=%b valid=%b addr=%0d data=%0d blk=%0d want all 0",
                  busy_o, curve_valid_o, curve_addr_o, curve_data_o, curve_block_o);
      else n_pass++;
   endtask

   task automatic test_uniform();
      bit to;
      int bad, nz;
      fill_uniform();
      build_expected(3, 16'hFFFF);
      start_block(3, 16'hFFFF);
      wait_done(to);
      n_checks++;
      if (to) $display("FAIL uniform_timeout: no done_o within budget");
      else n_pass++;
      n_checks++;
      if (got_q.size() != 128) $display("FAIL uniform_count: got %0d entries want 128", got_q.size());
      else n_pass++;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL uniform_entries: %0d entries differ from model", bad);
      else n_pass++;
      n_checks++;
      if ({got_data(0), got_data(63), got_data(127)} !== {8'd1, 8'd127, 8'd255})
         $display("FAIL uniform_spots: got %0d/%0d/%0d want 1/127/255", got_data(0), got_data(63), got_data(127));
      else n_pass++;
      nz = 0;
      for (int i = 0; i < 128; i++) if (!clr_seen[i] || hist_mem[i] != 0) nz++;
      n_checks++;
      if (clr_cnt != 128 || nz != 0) $display("FAIL uniform_clear: got %0d pulses, %0d bins uncleared, want 128/0", clr_cnt, nz);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_busy_bad != 0) $display("FAIL uniform_done: got %0d pulses (%0d with busy) want 1 (0)", done_cnt, done_busy_bad);
      else n_pass++;
   endtask

   task automatic test_single_bin();
      bit to;
      int bad;
      fill_single();
      build_expected(12, 16'hFFFF);
      start_block(12, 16'hFFFF);
      wait_done(to);
      n_checks++;
      if (to || got_q.size() != 128) $display("FAIL single_count: got %0d entries timeout=%0d want 128", got_q.size(), to);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL single_entries: %0d entries differ from model", bad);
      else n_pass++;
      n_checks++;
      if ({got_data(0), got_data(63), got_data(64), got_data(127)} !== {8'd0, 8'd0, 8'd255, 8'd255})
         $display("FAIL single_spots: got %0d/%0d/%0d/%0d want 0/0/255/255", got_data(0), got_data(63), got_data(64), got_data(127));
      else n_pass++;
   endtask

   task automatic test_clip_limit();
      bit to;
      int bad;
      logic [31:0] want;
`ifdef CURVE_CLIP_LIMIT_EN
      want = {8'd1, 8'd123, 8'd133, 8'd255};
`else
      want = {8'd0, 8'd0, 8'd255, 8'd255};
`endif
      fill_single();
      build_expected(21, 1024);
      start_block(21, 1024);
      wait_done(to);
      n_checks++;
      if (to || got_q.size() != 128) $display("FAIL clip_count: got %0d entries timeout=%0d want 128", got_q.size(), to);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL clip_entries: %0d entries differ from model", bad);
      else n_pass++;
      n_checks++;
      if ({got_data(0), got_data(63), got_data(64), got_data(127)} !== want)
         $display("FAIL clip_spots: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", got_data(0), got_data(63),
                  got_data(64), got_data(127), want[31:24], want[23:16], want[15:8], want[7:0]);
      else n_pass++;
   endtask

   task automatic test_stall();
      bit to, found;
      int bad, stall_bad;
      logic [22:0] first, cur;
      fill_random();
      build_expected(40, 300);
      start_block(40, 300);
      found = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge pclk);
         if (curve_valid_o && curve_ready_i && curve_addr_o == 7'd39) begin found = 1; break; end
      end
      @(posedge pclk);
      #1 curve_ready_i = 1'b0;
      stall_bad = 0;
      first = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge pclk);
         cur = {curve_valid_o, curve_addr_o, curve_data_o, curve_block_o};
         if (c == 0) first = cur;
         else if (cur !== first) stall_bad++;
      end
      n_checks++;
      if (!found || first[22:15] !== {1'b1, 7'd40})
         $display("FAIL stall_head: found=%0d valid=%b addr=%0d want valid=1 addr=40", found, first[22], first[21:15]);
      else n_pass++;
      n_checks++;
      if (stall_bad != 0) $display("FAIL stall_stable: %0d cycles changed while stalled, want 0", stall_bad);
      else n_pass++;
      @(posedge pclk);
      #1 curve_ready_i = 1'b1;
      wait_done(to);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (to || got_q.size() != 128 || bad != 0)
         $display("FAIL stall_entries: got %0d entries, %0d differ, timeout=%0d want 128/0/0", got_q.size(), bad, to);
      else n_pass++;
   endtask

   task automatic test_start_while_busy();
      bit to, was_busy;
      int bad;
      fill_random();
      build_expected(5, 500);
      start_block(5, 500);
      repeat (20) @(posedge pclk);
      #1;
      was_busy = busy_o;
      start_i = 1'b1;
      block_idx_i = 7'd9;
      clip_limit_i = 16'd7;
      @(posedge pclk);
      #1 start_i = 1'b0;
      n_checks++;
      if (was_busy !== 1'b1) $display("FAIL busy_high: got busy=%b want 1", was_busy);
      else n_pass++;
      wait_done(to);
      repeat (300) @(negedge pclk);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (to || got_q.size() != 128 || bad != 0)
         $display("FAIL busy_entries: got %0d entries, %0d differ, timeout=%0d want 128/0/0", got_q.size(), bad, to);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1) $display("FAIL busy_done: got %0d done pulses want 1", done_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to, found;
      int bad, untouched_bad;
      fill_random();
      start_block(17, 400);
      found = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge pclk);
         if (hist_clr_o && hist_clr_addr_o == 7'd49) begin found = 1; break; end
      end
      rst = 1'b1;
      @(negedge pclk);
      n_checks++;
      if (!found || {busy_o, curve_valid_o, hist_clr_o, done_o} !== 4'b0)
         $display("FAIL midreset_outputs: found=%0d busy=%b valid=%b clr=%b done=%b want 0", found, busy_o, curve_valid_o, hist_clr_o, done_o);
      else n_pass++;
      @(posedge pclk);
      #1 rst = 1'b0;
      untouched_bad = 0;
      for (int i = 0; i < 128; i++) begin
         if (i < 50 && hist_mem[i] != 0) untouched_bad++;
         if (i >= 50 && hist_mem[i] != ref_hist[i]) untouched_bad++;
      end
      n_checks++;
      if (untouched_bad != 0) $display("FAIL midreset_bins: %0d bins wrong (0..49 cleared, 50..127 untouched) want 0", untouched_bad);
      else n_pass++;
      fill_random();
      build_expected(18, 250);
      start_block(18, 250);
      wait_done(to);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (to || got_q.size() != 128 || bad != 0 || done_cnt != 1)
         $display("FAIL midreset_rerun: got %0d entries, %0d differ, done=%0d want 128/0/1", got_q.size(), bad, done_cnt);
      else n_pass++;
   endtask

   task automatic test_random_traffic();
      bit to;
      int bad, blk, clip;
      rand_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         fill_random();
         blk = $urandom_range(0, 79);
         clip = (it == 3) ? 65535 : $urandom_range(0, 800);
         build_expected(blk, clip);
         start_block(blk, clip);
         wait_done(to);
         bad = 0;
         for (int i = 0; i < got_q.size() && i < 128; i++) if (got_q[i] !== exp_q[i]) bad++;
         n_checks++;
         if (to || got_q.size() != 128 || bad != 0 || clr_cnt != 128)
            $display("FAIL random_run%0d: got %0d entries, %0d differ, %0d clears, timeout=%0d want 128/0/128/0",
                     it, got_q.size(), bad, clr_cnt, to);
         else n_pass++;
      end
      rand_ready = 1'b0;
      @(posedge pclk);
      #2 curve_ready_i = 1'b1;
   endtask

   initial begin
      clr_cnt = 0;
      done_cnt = 0;
      done_busy_bad = 0;
      for (int i = 0; i < 128; i++) begin hist_mem[i] = 0; ref_hist[i] = 0; clr_seen[i] = 1'b0; end
      test_reset();
      test_uniform();
      test_single_bin();
      test_clip_limit();
      test_stall();
      test_start_while_busy();
      test_reset_mid();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
